// File: rtl/poly_io_scheduler_pkg.sv
// Shared types for the polynomial I/O scheduler: command op codes, FSM states and sizing helper.
package poly_io_scheduler_pkg;

    localparam int unsigned ConfWidth = 3;

    typedef enum logic [1:0] {
        OpLoad   = 2'b00,
        OpRun    = 2'b01,
        OpUnload = 2'b10,
        OpRsvd   = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRun,
        StUnload,
        StUdrain
    } state_e;

    function automatic int unsigned num_coeffs(input int unsigned n_log);
        return 32'd1 << n_log;
    endfunction

endpackage

// File: rtl/poly_io_scheduler_if.sv
// Host command/stream, bank-side and core-control signals of the I/O scheduler.
interface poly_io_scheduler_if #(
    parameter int unsigned data_width = 14,
    parameter int unsigned n_log      = 10
);
    import poly_io_scheduler_pkg::*;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_op;
    logic [ConfWidth-1:0]  cmd_conf;
    logic                  s_valid;
    logic                  s_ready;
    logic [data_width-1:0] s_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [data_width-1:0] m_data;
    logic                  io_own;
    logic [n_log-1:0]      io_addr;
    logic [data_width-1:0] io_wdata;
    logic                  io_wen;
    logic                  io_ren;
    logic [data_width-1:0] io_rdata;
    logic [ConfWidth-1:0]  core_conf;
    logic                  core_start;
    logic                  core_done;
    logic                  busy;
    logic                  cmd_err;

    // Environment side: host, bank memory and core sequencer.
    modport master (
        output cmd_valid, cmd_op, cmd_conf, s_valid, s_data, m_ready, io_rdata, core_done,
        input  cmd_ready, s_ready, m_valid, m_data, io_own, io_addr, io_wdata, io_wen, io_ren,
               core_conf, core_start, busy, cmd_err
    );

    // Scheduler side.
    modport slave (
        input  cmd_valid, cmd_op, cmd_conf, s_valid, s_data, m_ready, io_rdata, core_done,
        output cmd_ready, s_ready, m_valid, m_data, io_own, io_addr, io_wdata, io_wen, io_ren,
               core_conf, core_start, busy, cmd_err
    );

endinterface

// File: rtl/poly_io_scheduler_sync_fifo.sv
// Synchronous FIFO with occupancy count; the writer guarantees it never pushes when full.
module poly_io_scheduler_sync_fifo #(
    parameter int unsigned depth = 4,
    parameter int unsigned width = 14
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [width-1:0]             wdata,
    input  logic                         pop,
    output logic [width-1:0]             rdata,
    output logic                         empty,
    output logic [$clog2(depth+1)-1:0]   count
);
    localparam int unsigned AddrW  = (depth > 1) ? $clog2(depth) : 1;
    localparam int unsigned CountW = $clog2(depth + 1);
    localparam logic [AddrW-1:0]  LastAddr = AddrW'(depth - 1);
    localparam logic [AddrW-1:0]  AddrOne  = AddrW'(1);
    localparam logic [CountW-1:0] CountOne = CountW'(1);

    logic [width-1:0]  mem_q [depth];
    logic [AddrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CountW-1:0] count_q;

    function automatic logic [AddrW-1:0] next_ptr(input logic [AddrW-1:0] ptr);
        return (ptr == LastAddr) ? '0 : ptr + AddrOne;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
            if (push && !pop) begin
                count_q <= count_q + CountOne;
            end else if (pop && !push) begin
                count_q <= count_q - CountOne;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/poly_io_scheduler.sv
// Owns the coefficient banks between NTT runs: streams loads in, launches the core,
// and streams results out through a credit-controlled skid FIFO.
module poly_io_scheduler
    import poly_io_scheduler_pkg::*;
#(
    parameter int unsigned data_width = 14,
    parameter int unsigned n_log      = 10,
    parameter int unsigned rd_lat     = 2,
    parameter int unsigned fifo_depth = 4
) (
    input logic               clk,
    input logic               rst,
    poly_io_scheduler_if.slave bus
);
    localparam int unsigned N      = num_coeffs(n_log);
    localparam int unsigned CntW   = n_log + 1;
    localparam int unsigned FcW    = $clog2(fifo_depth + 1);
    localparam int unsigned CrW    = $clog2(fifo_depth + rd_lat + 2) + 1;
    localparam logic [CntW-1:0] CntEnd  = CntW'(N);
    localparam logic [CntW-1:0] CntLast = CntW'(N - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [rd_lat-1:0]     rd_pipe_q, ren_vec;
    logic                  io_own_q, io_wen_q, io_ren_q, core_start_q, cmd_err_q;
    logic [n_log-1:0]      io_addr_q;
    logic [data_width-1:0] io_wdata_q;
    logic [ConfWidth-1:0]  core_conf_q;

    op_e                   op;
    logic                  cmd_ready, s_ready, accept, s_hs, pop, push, issue, fifo_empty;
    logic [FcW-1:0]        fifo_count;
    logic [CrW-1:0]        outstanding, credit;
    logic [data_width-1:0] fifo_head;

    assign op        = op_e'(bus.cmd_op);
    assign cmd_ready = (state_q == StIdle);
    assign s_ready   = (state_q == StLoad) && (cnt_q < CntEnd);
    assign accept    = bus.cmd_valid && cmd_ready;
    assign s_hs      = bus.s_valid && s_ready;
    assign pop       = !fifo_empty && bus.m_ready;
    assign push      = rd_pipe_q[rd_lat-1];

    // Reads in flight: the registered strobe plus every stage of the return pipe.
    always_comb begin
        outstanding = CrW'(io_ren_q);
        for (int i = 0; i < int'(rd_lat); i++) begin
            outstanding = outstanding + CrW'(rd_pipe_q[i]);
        end
    end

    always_comb begin
        ren_vec    = '0;
        ren_vec[0] = io_ren_q;
    end

    // A pop this cycle frees a slot long before any newly issued read can land in it.
    assign credit = outstanding + CrW'(fifo_count);
    assign issue  = (accept && op == OpUnload) ||
                    (state_q == StUnload && cnt_q < CntEnd &&
                     credit < CrW'(fifo_depth) + CrW'(pop));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    cnt_d = '0;
                    unique case (op)
                        OpLoad:   state_d = StLoad;
                        OpRun:    state_d = StRun;
                        OpUnload: begin
                            // Index 0 is issued on the accept cycle itself.
                            state_d = StUnload;
                            cnt_d   = CntOne;
                        end
                        default:  state_d = StIdle;
                    endcase
                end
            end
            StLoad: begin
                if (s_hs) begin
                    cnt_d = cnt_q + CntOne;
                    if (cnt_q == CntLast) state_d = StIdle;
                end
            end
            StRun: begin
                if (bus.core_done) state_d = StIdle;
            end
            StUnload: begin
                if (issue) begin
                    cnt_d = cnt_q + CntOne;
                    if (cnt_q == CntLast) state_d = StUdrain;
                end
            end
            StUdrain: begin
                if (outstanding == '0 && fifo_empty) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            rd_pipe_q    <= '0;
            io_own_q     <= 1'b1;
            io_wen_q     <= 1'b0;
            io_ren_q     <= 1'b0;
            io_addr_q    <= '0;
            io_wdata_q   <= '0;
            core_conf_q  <= '0;
            core_start_q <= 1'b0;
            cmd_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rd_pipe_q    <= (rd_pipe_q << 1) | ren_vec;
            io_own_q     <= (state_d != StRun);
            io_wen_q     <= s_hs;
            io_ren_q     <= issue;
            core_start_q <= accept && (op == OpRun);
            cmd_err_q    <= accept && (op == OpRsvd);
            if (accept && op == OpRun) core_conf_q <= bus.cmd_conf;
            if (s_hs) begin
                io_addr_q  <= cnt_q[n_log-1:0];
                io_wdata_q <= bus.s_data;
            end else if (issue) begin
                io_addr_q  <= (state_q == StIdle) ? '0 : cnt_q[n_log-1:0];
            end
        end
    end

    poly_io_scheduler_sync_fifo #(
        .depth (fifo_depth),
        .width (data_width)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (bus.io_rdata),
        .pop   (pop),
        .rdata (fifo_head),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bus.cmd_ready  = cmd_ready;
    assign bus.s_ready    = s_ready;
    assign bus.m_valid    = !fifo_empty;
    assign bus.m_data     = fifo_empty ? '0 : fifo_head;
    assign bus.io_own     = io_own_q;
    assign bus.io_addr    = io_addr_q;
    assign bus.io_wdata   = io_wdata_q;
    assign bus.io_wen     = io_wen_q;
    assign bus.io_ren     = io_ren_q;
    assign bus.core_conf  = core_conf_q;
    assign bus.core_start = core_start_q;
    assign bus.busy       = (state_q != StIdle);
    assign bus.cmd_err    = cmd_err_q;

endmodule
